reaction_timer: RTL and testbench
=================================

Name: reaction_timer

Overview:
- Downstream consumer of the reaction-test FSM's go/capture outputs.
- Measures elapsed time in milliseconds from the rising edge of go to the rising edge of capture, and latches the result.
- Keeps a running best (minimum) time and flags runs that saturated.
- Feeds the display/readout stage.

Parameters:
TICK_DIV, 50000, clk cycles per 1 ms tick (>=2)
CNT_W, 16, width of all millisecond counters/outputs
MAX_MS, 9999, saturation value of elapsed count (must fit in CNT_W)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
go  input  1  level from upstream FSM; high while stimulus shown
capture  input  1  level from upstream FSM; rises when user responds
clear_best  input  1  synchronous clear of best-time record
time_ms  output  CNT_W  last latched reaction time
result_valid  output  1  one-cycle pulse when time_ms updates
best_ms  output  CNT_W  minimum non-overflowed time since clear/reset
best_valid  output  1  best_ms holds a real result
running  output  1  high in TIMING state
overflow  output  1  elapsed saturated in current/last run

Behaviour:
- Reset (reset==0, async): state=IDLE; prescaler, elapsed, time_ms, best_ms = 0; result_valid, best_valid, running, overflow = 0; go_d, capture_d = 0.
- Edge detect: go_rise = go & ~go_d; cap_rise = capture & ~capture_d; go_d/capture_d registered every cycle.
- States:
  - IDLE: go_rise -> TIMING.
  - TIMING: running=1. cap_rise -> HOLD. go==0 with no cap_rise -> IDLE (abort).
  - HOLD: go_rise -> TIMING.
- Entering TIMING at edge E0: prescaler<=0, elapsed<=0, overflow<=0.
- Each later edge in TIMING: prescaler+1; when prescaler==TICK_DIV-1, prescaler<=0 and elapsed+1. Thus elapsed = floor(n/TICK_DIV) after edge E0+n.
- Saturation: when elapsed==MAX_MS a tick does not increment it and sets overflow=1. overflow stays 1 until the next TIMING entry or reset.
- Capture at edge E0+n (cap_rise high before it):
  - time_ms <= current elapsed, i.e. floor((n-1)/TICK_DIV). A tick on the same edge is discarded.
  - result_valid=1 for exactly that following cycle.
- Best update on capture: only if overflow==0 (including a saturation occurring on that same edge) and (best_valid==0 or elapsed<best_ms). Then best_ms<=elapsed, best_valid<=1. Equal value: no change.
- clear_best: best_ms<=0, best_valid<=0. If a capture best-update occurs on the same edge, the update wins (best_valid=1).
- Abort: time_ms, best_ms and overflow hold their values; no result_valid.
- cap_rise outside TIMING is ignored. go_rise while in TIMING is impossible by edge definition.
- Outputs time_ms/best_ms hold between events. No combinational path from inputs to outputs.

Test Plan (TICK_DIV=4, MAX_MS=10, CNT_W=8):
1. Hold reset=0 with go=1, capture=1 -> all outputs 0, state IDLE. Release reset -> no activity until a go_rise.
2. go rises; capture rises so cap_rise is seen at E0+14 -> time_ms=3, result_valid high 1 cycle, best_ms=3, best_valid=1, running low from then.
3. Next run captured at E0+22 -> time_ms=5, best_ms stays 3. Next run at E0+5 -> time_ms=1, best_ms=1. Run equal to best -> best unchanged.
4. go held 60 cycles then capture -> elapsed stops at 10, overflow=1 from the saturating tick, time_ms=10, result_valid pulses, best_ms unchanged. Next go_rise clears overflow.
5. go rises then falls after 9 cycles with capture=0 -> state IDLE, running=0, no result_valid, time_ms unchanged. clear_best coincident with an improving capture -> best_valid=1 with new value. clear_best alone -> best_ms=0, best_valid=0.
6. Assert reset=0 mid-TIMING (asynchronously, between edges) -> outputs clear immediately without a clock edge, best record lost; subsequent run measures correctly from 0.

Source files
------------

// File: rtl/reaction_timer_if.sv
// Handshake bundle between the reaction-test FSM, the timer
// and the display/readout stage.
interface reaction_timer_if #(
  parameter int CNT_W = 16
);
  logic             go;
  logic             capture;
  logic             clear_best;
  logic [CNT_W-1:0] time_ms;
  logic             result_valid;
  logic [CNT_W-1:0] best_ms;
  logic             best_valid;
  logic             running;
  logic             overflow;

  modport master (
    output go,
    output capture,
    output clear_best,
    input  time_ms,
    input  result_valid,
    input  best_ms,
    input  best_valid,
    input  running,
    input  overflow
  );

  modport slave (
    input  go,
    input  capture,
    input  clear_best,
    output time_ms,
    output result_valid,
    output best_ms,
    output best_valid,
    output running,
    output overflow
  );
endinterface

// File: rtl/reaction_timer.sv
// Millisecond reaction timer: go rise to capture rise,
// with latched result, running best time and saturation flag.
module reaction_timer #(
  parameter int TICK_DIV = 50000,
  parameter int CNT_W    = 16,
  parameter int MAX_MS   = 9999
) (
  input  logic            clk,
  input  logic            reset,
  reaction_timer_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] EMAX = CNT_W'(MAX_MS);

  typedef enum logic [1:0] {
    IDLE,
    TIMING,
    HOLD
  } state_t;

  state_t state;
  state_t state_nx;

  logic             go_d;
  logic             cap_d;
  logic [PW-1:0]    prescaler;
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] time_ms;
  logic [CNT_W-1:0] best_ms;
  logic             result_valid;
  logic             best_valid;
  logic             overflow;

  logic go_rise;
  logic cap_rise;
  logic timing;
  logic enter;
  logic capt;
  logic tick;
  logic sat;
  logic improve;

  always_comb begin
    go_rise  = bus.go & ~go_d;
    cap_rise = bus.capture & ~cap_d;
    timing   = (state == TIMING);
    enter    = go_rise & ~timing;
    capt     = timing & cap_rise;
    tick     = timing & (prescaler == PMAX);
    sat      = tick & (elapsed == EMAX);
    // A saturation on the capture edge still disqualifies the run
    improve  = capt & ~overflow & ~sat &
               (~best_valid | (elapsed < best_ms));
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (go_rise) state_nx = TIMING;
      end
      TIMING: begin
        if (cap_rise)     state_nx = HOLD;
        else if (!bus.go) state_nx = IDLE;
      end
      HOLD: begin
        if (go_rise) state_nx = TIMING;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      go_d  <= 1'b0;
      cap_d <= 1'b0;
    end else begin
      state <= state_nx;
      go_d  <= bus.go;
      cap_d <= bus.capture;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      elapsed   <= '0;
      overflow  <= 1'b0;
    end else if (enter) begin
      prescaler <= '0;
      elapsed   <= '0;
      overflow  <= 1'b0;
    end else if (timing) begin
      if (tick) begin
        prescaler <= '0;
        if (sat)        overflow <= 1'b1;
        else if (!capt) elapsed  <= elapsed + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      time_ms      <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= capt;
      if (capt) time_ms <= elapsed;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_ms    <= '0;
      best_valid <= 1'b0;
    end else if (improve) begin
      best_ms    <= elapsed;
      best_valid <= 1'b1;
    end else if (bus.clear_best) begin
      best_ms    <= '0;
      best_valid <= 1'b0;
    end
  end

  assign bus.time_ms      = time_ms;
  assign bus.result_valid = result_valid;
  assign bus.best_ms      = best_ms;
  assign bus.best_valid   = best_valid;
  assign bus.running      = timing;
  assign bus.overflow     = overflow;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with TICK_DIV=4,
// MAX_MS=10, CNT_W=8.
module tb_reaction_timer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reaction_timer_if #(.CNT_W(8)) bus ();

  reaction_timer #(
    .TICK_DIV(4),
    .CNT_W   (8),
    .MAX_MS  (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // capture rise seen at edge E0+n
  task automatic run(input int n, input bit clr);
    bus.go = 1'b1;
    step(1);
    check("running_e0", bus.running, 1);
    step(n - 1);
    bus.capture    = 1'b1;
    bus.clear_best = clr;
    step(1);
    bus.clear_best = 1'b0;
  endtask

  task automatic finish_run();
    check("rv_pulse_end", bus.result_valid, 0);
    bus.go      = 1'b0;
    bus.capture = 1'b0;
    step(2);
  endtask

  task automatic expect_out(
    input string tag,
    input int t, input int rv, input int b,
    input int bv, input int run_o, input int ov
  );
    check({tag, "_time"}, bus.time_ms, t);
    check({tag, "_rv"}, bus.result_valid, rv);
    check({tag, "_best"}, bus.best_ms, b);
    check({tag, "_bv"}, bus.best_valid, bv);
    check({tag, "_run"}, bus.running, run_o);
    check({tag, "_ovf"}, bus.overflow, ov);
  endtask

  initial begin
    bus.go         = 1'b1;
    bus.capture    = 1'b1;
    bus.clear_best = 1'b0;
    #23;
    expect_out("rst", 0, 0, 0, 0, 0, 0);
    bus.go      = 1'b0;
    bus.capture = 1'b0;
    #10 reset = 1'b1;
    step(3);
    expect_out("idle", 0, 0, 0, 0, 0, 0);

    run(14, 1'b0);
    expect_out("r14", 3, 1, 3, 1, 0, 0);
    step(1);
    finish_run();

    run(22, 1'b0);
    expect_out("r22", 5, 1, 3, 1, 0, 0);
    step(1);
    finish_run();

    run(5, 1'b0);
    expect_out("r5", 1, 1, 1, 1, 0, 0);
    step(1);
    finish_run();

    run(6, 1'b0);
    expect_out("req", 1, 1, 1, 1, 0, 0);
    step(1);
    finish_run();

    bus.go = 1'b1;
    step(1);
    step(43);
    check("ovf_pre", bus.overflow, 0);
    step(1);
    check("ovf_set", bus.overflow, 1);
    step(16);
    bus.capture = 1'b1;
    step(1);
    expect_out("rsat", 10, 1, 1, 1, 0, 1);
    step(1);
    finish_run();

    bus.go = 1'b1;
    step(1);
    check("ovf_clr", bus.overflow, 0);
    check("abort_run", bus.running, 1);
    step(8);
    bus.go = 1'b0;
    step(1);
    expect_out("abort", 10, 0, 1, 1, 0, 0);
    step(2);
    check("abort_rv", bus.result_valid, 0);

    run(2, 1'b1);
    expect_out("clrcap", 0, 1, 0, 1, 0, 0);
    step(1);
    finish_run();

    bus.clear_best = 1'b1;
    step(1);
    bus.clear_best = 1'b0;
    check("clr_best", bus.best_ms, 0);
    check("clr_bv", bus.best_valid, 0);

    run(9, 1'b0);
    expect_out("r9", 2, 1, 2, 1, 0, 0);
    step(1);
    finish_run();

    bus.go = 1'b1;
    step(7);
    #2 reset = 1'b0;
    #1;
    expect_out("async", 0, 0, 0, 0, 0, 0);
    bus.go = 1'b0;
    #3 reset = 1'b1;
    step(2);

    run(13, 1'b0);
    expect_out("r13", 3, 1, 3, 1, 0, 0);
    step(1);
    finish_run();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
